vga_cfg_sequencer: RTL

Upstream configuration stage for the VGA controller. It accepts resolution-change requests from system logic, buffers them in a small FIFO and rejects illegal modes. It skips requests that match the resolution already programmed. It drives the VGA configuration bus (c_valid/c_addr/c_data, back-pressured by c_ready) one transaction at a time, with a timeout and a post-write cooldown.

---
 rtl/vga_cfg_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vga_cfg_sequencer.sv
// Configuration-side front end of the VGA controller: queues resolution requests,
// drops illegal or already-programmed modes and writes the rest over the config bus.
//
// state | meaning
// IDLE  | waiting; pops the FIFO head and skips it if it matches cur_mode
// ISSUE | c_valid held stable until c_ready or the timeout expires
// COOL  | quiet period of COOLDOWN cycles after every transaction
module vga_cfg_sequencer #(
    parameter int                      CONFIG_WIDTH = 2,
    parameter int                      FIFO_DEPTH   = 4,
    parameter int                      TIMEOUT      = 255,
    parameter int                      COOLDOWN     = 2,
    parameter logic [CONFIG_WIDTH-1:0] VGA_ADDR     = CONFIG_WIDTH'(2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [CONFIG_WIDTH-1:0] req_mode,
    output logic                    req_ready,
    output logic                    c_valid,
    output logic [CONFIG_WIDTH-1:0] c_addr,
    output logic [CONFIG_WIDTH-1:0] c_data,
    input  logic                    c_ready,
    output logic [CONFIG_WIDTH-1:0] cur_mode,
    output logic                    busy,
    output logic                    err_badmode,
    output logic                    err_timeout
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int CD_W  = $clog2(COOLDOWN + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t                  state;
    logic [TMR_W-1:0]        tmr;
    logic [CD_W-1:0]         cool_cnt;

    logic [CONFIG_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    mode_legal;
    logic                    req_accept;
    logic                    push;
    logic                    pop;
    logic [CONFIG_WIDTH-1:0] head;

    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign mode_legal = (req_mode < CONFIG_WIDTH'(3));
    assign req_ready  = !rst && !fifo_full;
    assign req_accept = req_valid && req_ready;
    assign push       = req_accept && mode_legal;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];
    assign busy       = (state != IDLE) || !fifo_empty;

    // Pointers wrap for free because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            err_badmode <= 1'b0;
        end else begin
            err_badmode <= req_accept && !mode_legal;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= req_mode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            c_valid     <= 1'b0;
            c_addr      <= '0;
            c_data      <= '0;
            cur_mode    <= '0;
            err_timeout <= 1'b0;
            tmr         <= '0;
            cool_cnt    <= '0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop && head != cur_mode) begin
                        c_valid <= 1'b1;
                        c_addr  <= VGA_ADDR;
                        c_data  <= head;
                        tmr     <= TMR_W'(TIMEOUT - 1);
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A handshake on the last allowed cycle still counts as a success.
                    if (c_ready || tmr == '0) begin
                        c_valid <= 1'b0;
                        c_addr  <= '0;
                        c_data  <= '0;
                        if (c_ready) cur_mode <= c_data;
                        else         err_timeout <= 1'b1;
                        if (COOLDOWN == 0) begin
                            state <= IDLE;
                        end else begin
                            state    <= COOL;
                            cool_cnt <= CD_W'(COOLDOWN - 1);
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                COOL: begin
                    if (cool_cnt == '0) state <= IDLE;
                    else                cool_cnt <= cool_cnt - CD_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
